// File: rtl/sha256_round_ctrl.sv
// Sequencing controller for one SHA-256 compression: load, ROUNDS round updates,
// feed-forward, then hold the digest until the consumer acknowledges it.
module sha256_round_ctrl #(
    parameter int ROUNDS = 64,
    parameter int CNT_W  = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             first_block,
    input  logic             abort,
    input  logic             digest_ack,
    output logic             ready,
    output logic             pipe_load,
    output logic             pipe_en,
    output logic [5:0]       round_idx,
    output logic             w_sel,
    output logic             iv_sel,
    output logic             feed_fwd,
    output logic             digest_valid,
    output logic [CNT_W-1:0] blk_cnt
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        ROUND = 3'd2,
        FINAL = 3'd3,
        DONE  = 3'd4
    } state_t;

    localparam logic [5:0] LAST_ROUND = 6'(ROUNDS - 1);
    localparam logic [5:0] FIRST_EXP  = 6'd16;

    state_t           state;
    state_t           state_nxt;
    logic [5:0]       idx_nxt;
    logic             iv_nxt;
    logic [CNT_W-1:0] cnt_nxt;

    always_comb begin
        state_nxt = state;
        idx_nxt   = 6'd0;
        iv_nxt    = iv_sel;
        cnt_nxt   = blk_cnt;
        case (state)
            IDLE: begin
                if (start && !abort) begin
                    state_nxt = LOAD;
                    iv_nxt    = first_block;
                end
            end
            LOAD:  state_nxt = ROUND;
            ROUND: begin
                if (round_idx == LAST_ROUND) begin
                    state_nxt = FINAL;
                end else begin
                    idx_nxt = round_idx + 6'd1;
                end
            end
            FINAL: state_nxt = DONE;
            DONE: begin
                if (digest_ack) begin
                    state_nxt = IDLE;
                    cnt_nxt   = blk_cnt + CNT_W'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase
        // Abort cancels everything outside IDLE, including a same-cycle acknowledge.
        if (abort && (state != IDLE)) begin
            state_nxt = IDLE;
            idx_nxt   = 6'd0;
            cnt_nxt   = blk_cnt;
        end
    end

    // Outputs are decoded from the next state so every output comes straight off a flop.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            round_idx    <= 6'd0;
            ready        <= 1'b1;
            pipe_load    <= 1'b0;
            pipe_en      <= 1'b0;
            w_sel        <= 1'b0;
            iv_sel       <= 1'b1;
            feed_fwd     <= 1'b0;
            digest_valid <= 1'b0;
            blk_cnt      <= '0;
        end else begin
            state        <= state_nxt;
            round_idx    <= idx_nxt;
            ready        <= (state_nxt == IDLE);
            pipe_load    <= (state_nxt == LOAD);
            pipe_en      <= (state_nxt == ROUND);
            w_sel        <= (state_nxt == ROUND) && (idx_nxt >= FIRST_EXP);
            iv_sel       <= iv_nxt;
            feed_fwd     <= (state_nxt == FINAL);
            digest_valid <= (state_nxt == DONE);
            blk_cnt      <= cnt_nxt;
        end
    end

endmodule

// File: tb/tb_sha256_round_ctrl.sv
// Directed bench for sha256_round_ctrl: vector table for short control cases,
// hand-written sequences for full blocks, aborts, reset mid-block and counter wrap.
module tb_sha256_round_ctrl;

    localparam int ROUNDS = 64;
    localparam int CNT_W  = 2;

    logic             clk;
    logic             rst;
    logic             start;
    logic             first_block;
    logic             abort;
    logic             digest_ack;
    logic             ready;
    logic             pipe_load;
    logic             pipe_en;
    logic [5:0]       round_idx;
    logic             w_sel;
    logic             iv_sel;
    logic             feed_fwd;
    logic             digest_valid;
    logic [CNT_W-1:0] blk_cnt;

    sha256_round_ctrl #(.ROUNDS(ROUNDS), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .first_block  (first_block),
        .abort        (abort),
        .digest_ack   (digest_ack),
        .ready        (ready),
        .pipe_load    (pipe_load),
        .pipe_en      (pipe_en),
        .round_idx    (round_idx),
        .w_sel        (w_sel),
        .iv_sel       (iv_sel),
        .feed_fwd     (feed_fwd),
        .digest_valid (digest_valid),
        .blk_cnt      (blk_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Packed view: {ready, pipe_load, pipe_en, round_idx[5:0], w_sel, iv_sel, feed_fwd, digest_valid, blk_cnt[1:0]}
    logic [14:0] outs;
    assign outs = {ready, pipe_load, pipe_en, round_idx, w_sel, iv_sel, feed_fwd, digest_valid, blk_cnt};

    int pass_cnt  = 0;
    int total_cnt = 0;

    typedef struct {
        logic        rst;
        logic        start;
        logic        fb;
        logic        abort;
        logic        ack;
        logic [14:0] exp;
    } vec_t;

    vec_t vt[14];

    function automatic logic [14:0] ep(input logic r, input logic pl, input logic pe,
                                       input logic [5:0] idx, input logic ws, input logic iv,
                                       input logic ff, input logic dv, input logic [1:0] c);
        return {r, pl, pe, idx, ws, iv, ff, dv, c};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [14:0] exp);
        total_cnt++;
        if (outs !== exp)
            $display("FAIL %s: got %h (rdy,pl,pe,idx,ws,iv,ff,dv,cnt) required %h", nm, outs, exp);
        else
            pass_cnt++;
    endtask

    task automatic chk32(input string nm, input int act, input int exp);
        total_cnt++;
        if (act != exp)
            $display("FAIL %s: got %0d required %0d", nm, act, exp);
        else
            pass_cnt++;
    endtask

    task automatic start_block(input logic fb, input logic [1:0] cnt);
        start       = 1'b1;
        first_block = fb;
        tick();
        start       = 1'b0;
        first_block = 1'b0;
        chk("load", ep(0, 1, 0, 6'd0, 0, fb, 0, 0, cnt));
    endtask

    task automatic rounds(input logic fb, input logic [1:0] cnt, input int from, input int last);
        for (int i = from; i <= last; i++) begin
            tick();
            chk($sformatf("round%0d", i), ep(0, 0, 1, 6'(i), (i >= 16), fb, 0, 0, cnt));
        end
    endtask

    task automatic final_done(input logic fb, input logic [1:0] cnt);
        tick();
        chk("final", ep(0, 0, 0, 6'd0, 0, fb, 1, 0, cnt));
        tick();
        chk("done", ep(0, 0, 0, 6'd0, 0, fb, 0, 1, cnt));
    endtask

    task automatic finish_ack(input logic fb, input logic [1:0] cnt_after);
        digest_ack = 1'b1;
        tick();
        digest_ack = 1'b0;
        chk("ack_idle", ep(1, 0, 0, 6'd0, 0, fb, 0, 0, cnt_after));
    endtask

    initial begin
        logic [14:0] idle1;
        logic [1:0]  wrap_exp[5];
        int          strobes;

        rst = 1'b0; start = 1'b0; first_block = 1'b0; abort = 1'b0; digest_ack = 1'b0;
        idle1 = ep(1, 0, 0, 6'd0, 0, 1, 0, 0, 2'd0);

        //            rst start fb abort ack  expected after the edge
        vt[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, idle1};
        vt[1]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, idle1};
        vt[2]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, idle1};
        vt[3]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, idle1};
        vt[4]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, ep(0, 1, 0, 6'd0, 0, 0, 0, 0, 2'd0)};
        vt[5]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ep(0, 0, 1, 6'd0, 0, 0, 0, 0, 2'd0)};
        vt[6]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, ep(0, 0, 1, 6'd1, 0, 0, 0, 0, 2'd0)};
        vt[7]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, ep(0, 0, 1, 6'd2, 0, 0, 0, 0, 2'd0)};
        vt[8]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, ep(1, 0, 0, 6'd0, 0, 0, 0, 0, 2'd0)};
        vt[9]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, ep(0, 1, 0, 6'd0, 0, 1, 0, 0, 2'd0)};
        vt[10] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, ep(1, 0, 0, 6'd0, 0, 1, 0, 0, 2'd0)};
        vt[11] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, ep(0, 1, 0, 6'd0, 0, 0, 0, 0, 2'd0)};
        vt[12] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, idle1};
        vt[13] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, idle1};

        for (int v = 0; v < 14; v++) begin
            rst         = vt[v].rst;
            start       = vt[v].start;
            first_block = vt[v].fb;
            abort       = vt[v].abort;
            digest_ack  = vt[v].ack;
            tick();
            chk($sformatf("vec%0d", v), vt[v].exp);
        end
        rst = 1'b0; start = 1'b0; first_block = 1'b0; abort = 1'b0; digest_ack = 1'b0;

        // Full first block from IV, digest held for 5 cycles before acknowledge.
        start_block(1'b1, 2'd0);
        rounds(1'b1, 2'd0, 0, 63);
        final_done(1'b1, 2'd0);
        for (int k = 0; k < 5; k++) begin
            tick();
            chk($sformatf("done_hold%0d", k), ep(0, 0, 0, 6'd0, 0, 1, 0, 1, 2'd0));
        end
        finish_ack(1'b1, 2'd1);

        // Chained block with a stray start pulse mid-rounds.
        start_block(1'b0, 2'd1);
        rounds(1'b0, 2'd1, 0, 10);
        start = 1'b1;
        first_block = 1'b1;
        rounds(1'b0, 2'd1, 11, 11);
        start = 1'b0;
        first_block = 1'b0;
        rounds(1'b0, 2'd1, 12, 63);
        final_done(1'b0, 2'd1);
        finish_ack(1'b0, 2'd2);

        // Abort at round 30, then confirm the block never resumes.
        start_block(1'b1, 2'd2);
        rounds(1'b1, 2'd2, 0, 30);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_r30", ep(1, 0, 0, 6'd0, 0, 1, 0, 0, 2'd2));
        strobes = 0;
        for (int k = 0; k < 70; k++) begin
            tick();
            if (pipe_en || feed_fwd || digest_valid || !ready) strobes++;
        end
        chk32("abort_r30_quiet", strobes, 0);

        // Abort while feed_fwd is asserted.
        start_block(1'b0, 2'd2);
        rounds(1'b0, 2'd2, 0, 63);
        tick();
        chk("final_b4", ep(0, 0, 0, 6'd0, 0, 0, 1, 0, 2'd2));
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_final", ep(1, 0, 0, 6'd0, 0, 0, 0, 0, 2'd2));
        tick();
        chk("abort_final_stay", ep(1, 0, 0, 6'd0, 0, 0, 0, 0, 2'd2));

        // Abort and acknowledge together in DONE: abort wins.
        start_block(1'b1, 2'd2);
        rounds(1'b1, 2'd2, 0, 63);
        final_done(1'b1, 2'd2);
        abort = 1'b1;
        digest_ack = 1'b1;
        tick();
        abort = 1'b0;
        digest_ack = 1'b0;
        chk("abort_ack_done", ep(1, 0, 0, 6'd0, 0, 1, 0, 0, 2'd2));

        // Reset in the middle of ROUND clears everything including the counter.
        start_block(1'b0, 2'd2);
        rounds(1'b0, 2'd2, 0, 5);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_round", idle1);

        // Five completed blocks on a 2-bit counter.
        wrap_exp[0] = 2'd1; wrap_exp[1] = 2'd2; wrap_exp[2] = 2'd3; wrap_exp[3] = 2'd0; wrap_exp[4] = 2'd1;
        for (int b = 0; b < 5; b++) begin
            logic [1:0] cb;
            cb = (b == 0) ? 2'd0 : wrap_exp[b-1];
            start_block(1'b1, cb);
            rounds(1'b1, cb, 0, 63);
            final_done(1'b1, cb);
            finish_ack(1'b1, wrap_exp[b]);
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/sha256_round_ctrl.md
SHA256_ROUND_CTRL -- requirements
Module: sha256_round_ctrl

Interface
REQ-001 Parameter: ROUNDS, 64, number of compression rounds per block; legal range 17..64.
REQ-002 Parameter: CNT_W, 32, width of the completed-block counter.
REQ-003 Port: clk  input  1  single clock; all logic on rising edge.
REQ-004 Port: rst  input  1  reset, synchronous and active-high.
REQ-005 Port: start  input  1  request to hash one 512-bit block; accepted only when ready=1.
REQ-006 Port: first_block  input  1  sampled with accepted start; 1 = use IV, 0 = chain previous H.
REQ-007 Port: abort  input  1  cancel the block in progress.
REQ-008 Port: digest_ack  input  1  consumer has taken the digest.
REQ-009 Port: ready  output  1  controller idle, start will be accepted.
REQ-010 Port: pipe_load  output  1  one-cycle strobe loading working registers a..h from the chaining value.
REQ-011 Port: pipe_en  output  1  round register update enable.
REQ-012 Port: round_idx  output  6  current round t; selects K[t] and W[t].
REQ-013 Port: w_sel  output  1  0 = W from message word t, 1 = W from schedule expansion.
REQ-014 Port: iv_sel  output  1  chaining source for pipe_load and feed-forward: 1 = IV, 0 = H.
REQ-015 Port: feed_fwd  output  1  one-cycle strobe: H <= H + {a..h}.
REQ-016 Port: digest_valid  output  1  digest in H is final; held until acknowledged.
REQ-017 Port: blk_cnt  output  CNT_W  count of completed (acknowledged) blocks.

Function
REQ-018 All outputs SHALL be registered; states are IDLE, LOAD, ROUND, FINAL, DONE.
REQ-019 IDLE: ready=1, all strobes 0; start=1 -> LOAD; first_block latched into iv_sel at the same edge.
REQ-020 LOAD: pipe_load=1 for exactly one cycle, round_idx=0 -> ROUND.
REQ-021 ROUND: pipe_en=1 every cycle; round_idx starts at 0 and increments by 1 per cycle.
REQ-022 ROUND with round_idx=ROUNDS-1 -> FINAL; round_idx never exceeds ROUNDS-1.
REQ-023 w_sel=1 exactly when in ROUND and round_idx>=16; else 0.
REQ-024 FINAL: feed_fwd=1 for exactly one cycle, pipe_en=0 -> DONE.
REQ-025 DONE: digest_valid=1 until digest_ack=1; then -> IDLE and blk_cnt increments, wrapping modulo 2^CNT_W.
REQ-026 round_idx SHALL read 0 in every state other than ROUND.
REQ-027 Latency: start accepted at edge N -> pipe_load in cycle N+1, pipe_en cycles N+2..N+1+ROUNDS, feed_fwd cycle N+2+ROUNDS, digest_valid from cycle N+3+ROUNDS.
REQ-028 start while ready=0 SHALL be ignored and not queued.
REQ-029 abort in LOAD, ROUND, FINAL or DONE -> IDLE next edge; no further pipe_en/feed_fwd; blk_cnt unchanged.
REQ-030 abort and digest_ack in the same DONE cycle: abort wins, blk_cnt unchanged.
REQ-031 abort in IDLE has no effect; abort and start together in IDLE: abort wins, start ignored.
REQ-032 digest_ack outside DONE SHALL be ignored.
REQ-033 iv_sel SHALL hold its latched value from LOAD through DONE.

Reset
REQ-034 rst=1 at any edge, in any state, SHALL force IDLE: ready=1, iv_sel=1, blk_cnt=0, all other outputs 0; rst overrides every other input.

Verification
REQ-035 Reset, start=1 with first_block=1 at edge 0 -> ready=0, pipe_load cycle 1, pipe_en cycles 2..65 with round_idx 0..63, w_sel rises at round_idx=16, feed_fwd cycle 66, digest_valid cycle 67.
REQ-036 digest_ack held low 5 cycles in DONE -> digest_valid stays 1, no strobes; ack -> ready=1 next cycle, blk_cnt=1.
REQ-037 Second block, start with first_block=0 -> iv_sel=0 from LOAD through DONE, blk_cnt=2 after ack.
REQ-038 abort at round_idx=30 -> IDLE next edge, pipe_en=0, feed_fwd never asserted, blk_cnt unchanged.
REQ-039 start pulsed during ROUND -> ignored, sequence length unchanged; rst asserted in ROUND -> all outputs at reset values after that edge.
REQ-040 CNT_W=2, five blocks completed -> blk_cnt reads 1,2,3,0,1.
